up_counter_prog: RTL and testbench
==================================

Name: up_counter_prog

Overview:
Parametrised successor to the fixed 8-bit up counter. Provides:
- N-bit up/down counting with a programmable modulo terminal value.
- Synchronous parallel load.
- A programmable tick prescaler.
- Three end-of-count modes: wrap, saturate, one-shot.
- A single-cycle terminal-count pulse and a sticky done flag.

Used as the generic event/interval counter in timers and rate dividers.

Parameters:
WIDTH, 8, counter width in bits (>=2)
PRE_W, 4, prescaler divisor width in bits (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  count enable; gates the prescaler and the counter
up_dn  in  1  1 = count up, 0 = count down; sampled on every tick
load  in  1  synchronous load strobe
load_val  in  WIDTH  value loaded when load=1
modulo  in  WIDTH  terminal value; the count range is 0..modulo
mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as WRAP)
prescale  in  PRE_W  tick every prescale+1 enabled cycles; 0 = every enabled cycle
out  out  WIDTH  current count
tc  out  1  single-cycle pulse on a tick that reaches a terminal condition
done  out  1  ONESHOT only: sticky, set when the terminal value is reached

Behaviour:
- Reset values: out=0, tc=0, done=0, prescaler counter=0.
- Priority per cycle: reset > load > tick > hold.
- Load:
  - out<=load_val, done<=0, prescaler<=0, tc=0.
  - Takes effect regardless of enable.
  - load_val>modulo is accepted as-is.
- Prescaler:
  - Internal counter pc, advanced only while enable=1.
  - tick=1 in the cycle where enable=1 and pc==prescale; pc then goes to 0, otherwise pc<=pc+1.
  - With enable=0, pc holds.
  - A change of prescale mid-count applies from the next comparison; if pc>prescale, pc wraps through its PRE_W range with no special handling.
- Terminal condition, evaluated on tick with the pre-update value:
  - up: out>=modulo.
  - down: out==0.
- On tick with no terminal condition: out<=out+1 (up) or out-1 (down).
- On tick with the terminal condition: tc=1 for that cycle, then per mode:
  - WRAP: up -> out<=0; down -> out<=modulo.
  - SAT: out holds. tc pulses on every tick while terminal, so the bench must count pulses.
  - ONESHOT: out holds and done<=1. While done=1, ticks are ignored: no change, no tc, prescaler frozen. Only load or reset clears done.
- tc latency: tc is registered and asserts in the same cycle the out update is registered, i.e. one cycle after the tick edge. tc is never asserted with enable=0 at the tick.
- modulo=0:
  - out stays 0.
  - WRAP/SAT: tc on every tick.
  - ONESHOT: done on the first tick.
- Direction change: up_dn is sampled each tick; no state is kept. Changing direction while at a terminal value re-evaluates against the new direction.
- mode change mid-count: effective at the next tick. A done flag already set persists until load/reset even if mode leaves ONESHOT; ticks are then ignored only while mode==ONESHOT.
- Arithmetic is modulo 2^WIDTH. With modulo=2^WIDTH-1 the natural wrap coincides with WRAP mode.

Decomposition:
- Shared package:
  - mode localparams MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_ONESHOT=2'd2.
  - Direction constants DIR_UP=1'b1, DIR_DN=1'b0.
- One sub-module, counter_prescaler:
  - Parameter PRE_W.
  - Ports: clk, reset, clr, enable, freeze, prescale, tick.
  - Instantiated once; load drives clr, ONESHOT&done drives freeze.

Test Plan:
- Reset mid-count: WIDTH=8, WRAP, prescale=0, enable=1, count to 37, assert reset 1 cycle -> next cycle out=0, tc=0, done=0; counting resumes 1,2,...
- Up wrap: modulo=9, up, WRAP, prescale=0 -> out 0..9,0,1; tc high exactly on the cycle out returns 0; 10-cycle period.
- Down saturate with prescaler: load 3, prescale=2, down, SAT -> out changes every 3 enabled cycles 3,2,1,0 then holds 0; tc pulses every 3 cycles thereafter; enable=0 for 5 cycles freezes out and pc.
- ONESHOT: load 0, modulo=5, up -> out reaches 5, next tick tc=1 and done=1, out holds 5 for 20 cycles with no further tc; load 2 -> done=0, counting resumes 3,4,5.
- Load priority and out-of-range load: load=1 coinciding with a tick, load_val=200, modulo=100, up, WRAP -> out=200 (no increment); next tick tc=1, out=0.
- modulo=0 and direction flip: modulo=0, WRAP -> out stays 0, tc every tick. Then modulo=50 at out=50, flip up->down -> next tick out=49, no tc.

Source files
------------

// File: rtl/up_counter_prog_pkg.sv
// up_counter_prog shared definitions.
// Mode and direction encodings used by the counter and its users.
package up_counter_prog_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // The reserved encoding falls back to wrap behaviour.
    function automatic logic is_oneshot(input logic [1:0] m);
        return (m == MODE_ONESHOT);
    endfunction

    function automatic logic is_sat(input logic [1:0] m);
        return (m == MODE_SAT);
    endfunction

endpackage

// File: rtl/up_counter_prog_if.sv
// up_counter_prog control/status bundle.
// master drives the controls, slave is the counter.
interface up_counter_prog_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
);

    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulo;
    logic [1:0]       mode;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             done;

    modport master (
        output enable,
        output up_dn,
        output load,
        output load_val,
        output modulo,
        output mode,
        output prescale,
        input  out,
        input  tc,
        input  done
    );

    modport slave (
        input  enable,
        input  up_dn,
        input  load,
        input  load_val,
        input  modulo,
        input  mode,
        input  prescale,
        output out,
        output tc,
        output done
    );

endinterface

// File: rtl/up_counter_prog_counter_prescaler.sv
// Tick prescaler: one tick every prescale+1 enabled cycles.
// clr restarts the count, freeze holds it and suppresses ticks.
module counter_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             enable,
    input  logic             freeze,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pc_q;
    logic             run;

    assign run  = enable & ~freeze;
    assign tick = run & (pc_q == prescale);

    // pc restarts after each tick; a pc above prescale simply rolls over.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (clr) begin
            pc_q <= '0;
        end else if (run) begin
            if (tick) pc_q <= '0;
            else      pc_q <= pc_q + 1'b1;
        end
    end

endmodule

// File: rtl/up_counter_prog.sv
// Programmable up/down modulo counter with prescaler.
// Wrap, saturate and one-shot end-of-count modes.
module up_counter_prog
    import up_counter_prog_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input logic clk,
    input logic reset,
    up_counter_prog_if.slave bus
);

    logic [WIDTH-1:0] cnt_q;
    logic             tc_q;
    logic             done_q;
    logic             tick;
    logic             freeze;
    logic             term;
    logic             going_up;

    assign going_up = (bus.up_dn == DIR_UP);
    assign freeze   = done_q & is_oneshot(bus.mode);

    // Terminal test uses the count before this tick's update.
    always_comb begin
        term = 1'b0;
        if (going_up) term = (cnt_q >= bus.modulo);
        else          term = (cnt_q == '0);
    end

    counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_pre (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.load),
        .enable   (bus.enable),
        .freeze   (freeze),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    // Count, terminal pulse and sticky done: reset > load > tick > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.load) begin
            cnt_q  <= bus.load_val;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (tick) begin
                if (term) begin
                    tc_q <= 1'b1;
                    if (is_oneshot(bus.mode)) begin
                        done_q <= 1'b1;
                    end else if (!is_sat(bus.mode)) begin
                        cnt_q <= going_up ? '0 : bus.modulo;
                    end
                end else begin
                    cnt_q <= going_up ? cnt_q + 1'b1
                                      : cnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.out  = cnt_q;
    assign bus.tc   = tc_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_up_counter_prog.sv
// Directed bench for up_counter_prog.
// Hand-computed expectations, sampled 1 time unit after each edge.
module tb_up_counter_prog;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;
    int   pulses;

    up_counter_prog_if #(.WIDTH(8), .PRE_W(4)) bus ();

    up_counter_prog #(
        .WIDTH (8),
        .PRE_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        bus.load_val = 8'(v);
        bus.load     = 1'b1;
        cyc();
        bus.load     = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.modulo   = 8'd255;
        bus.mode     = 2'd0;
        bus.prescale = '0;
        cyc();
        cyc();
        chk("rst_out", int'(bus.out), 0);
        chk("rst_tc", int'(bus.tc), 0);
        chk("rst_done", int'(bus.done), 0);

        // reset mid-count
        reset      = 1'b0;
        bus.enable = 1'b1;
        repeat (37) cyc();
        chk("cnt37", int'(bus.out), 37);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_out", int'(bus.out), 0);
        chk("mid_rst_tc", int'(bus.tc), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        cyc();
        chk("resume1", int'(bus.out), 1);
        cyc();
        chk("resume2", int'(bus.out), 2);

        // up wrap, modulo 9
        bus.modulo = 8'd9;
        do_load(0);
        chk("wrap_load", int'(bus.out), 0);
        for (int i = 1; i <= 11; i++) begin
            cyc();
            chk("wrap_out", int'(bus.out), i % 10);
            chk("wrap_tc", int'(bus.tc), (i == 10) ? 1 : 0);
        end

        // down saturate with prescale 2
        bus.mode     = 2'd1;
        bus.up_dn    = 1'b0;
        bus.prescale = 4'd2;
        do_load(3);
        chk("sat_load", int'(bus.out), 3);
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("sat_out", int'(bus.out),
                (k < 3) ? 3 : (k < 6) ? 2 : (k < 9) ? 1 : 0);
            if (bus.tc) pulses++;
        end
        chk("sat_pulses", pulses, 2);
        bus.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("dis_out", int'(bus.out), 0);
            chk("dis_tc", int'(bus.tc), 0);
        end
        bus.enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("pc_frozen_tc", int'(bus.tc), (k == 3) ? 1 : 0);
        end

        // one-shot
        bus.mode     = 2'd2;
        bus.up_dn    = 1'b1;
        bus.prescale = '0;
        bus.modulo   = 8'd5;
        do_load(0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("os_out", int'(bus.out), k);
            chk("os_tc", int'(bus.tc), 0);
        end
        cyc();
        chk("os_term_tc", int'(bus.tc), 1);
        chk("os_term_done", int'(bus.done), 1);
        chk("os_term_out", int'(bus.out), 5);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (bus.tc) pulses++;
        end
        chk("os_no_tc", pulses, 0);
        chk("os_hold", int'(bus.out), 5);
        chk("os_sticky", int'(bus.done), 1);
        do_load(2);
        chk("os_reload_out", int'(bus.out), 2);
        chk("os_reload_done", int'(bus.done), 0);
        for (int k = 3; k <= 5; k++) begin
            cyc();
            chk("os_resume", int'(bus.out), k);
        end

        // load beats tick; out-of-range load value
        bus.mode   = 2'd0;
        bus.modulo = 8'd100;
        do_load(200);
        chk("ld_pri_out", int'(bus.out), 200);
        chk("ld_pri_tc", int'(bus.tc), 0);
        cyc();
        chk("ovr_tc", int'(bus.tc), 1);
        chk("ovr_out", int'(bus.out), 0);

        // modulo 0 in wrap
        bus.modulo = 8'd0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("m0_out", int'(bus.out), 0);
            chk("m0_tc", int'(bus.tc), 1);
        end

        // modulo 0 in one-shot, then leave one-shot with done set
        bus.mode = 2'd2;
        do_load(0);
        cyc();
        chk("m0os_done", int'(bus.done), 1);
        chk("m0os_tc", int'(bus.tc), 1);
        cyc();
        chk("m0os_quiet", int'(bus.tc), 0);
        bus.mode = 2'd0;
        cyc();
        chk("done_persist", int'(bus.done), 1);
        chk("wrap_after_os", int'(bus.tc), 1);

        // direction flip at terminal value
        bus.modulo = 8'd50;
        do_load(50);
        chk("flip_load", int'(bus.out), 50);
        bus.up_dn = 1'b0;
        cyc();
        chk("flip_out", int'(bus.out), 49);
        chk("flip_tc", int'(bus.tc), 0);

        // reserved mode behaves as wrap
        bus.mode   = 2'd3;
        bus.up_dn  = 1'b1;
        bus.modulo = 8'd2;
        do_load(2);
        cyc();
        chk("rsv_out", int'(bus.out), 0);
        chk("rsv_tc", int'(bus.tc), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
